// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - oversampled start/stop serial receiver with a one-entry valid/ready output buffer
// The line is double-flopped; every decision uses sin_s, and mid-bit sampling comes from the per-bit counter.
module serial_rx #(
  parameter int WIDTH = 5,
  parameter int OVS   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CNT_W = $clog2(OVS);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVS / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_RECOVER
  } state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;
  logic               sin_s;
  logic               good_word;
  logic               load;

  assign sin_s = sync2_q;

  always_comb begin
    state_d     = state_q;
    sync1_d     = sin;
    sync2_d     = sync1_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    good_word   = 1'b0;
    load        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!sin_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        // A start bit that is high again at mid-bit is a glitch, not a frame.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = sin_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = sin_s;
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (sin_s) begin
            good_word = 1'b1;
            state_d   = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_RECOVER;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RECOVER: begin
        if (sin_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A word arriving while the buffer is being drained in the same cycle still lands.
    load = good_word && (!valid_q || ready);
    if (load) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end else if (good_word) begin
      overrun_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
